// File: rtl/branch_resolve_if.sv
// Bundle between decode, the comparator, fetch redirect and writeback for the
// execute-stage branch resolution unit.
interface branch_resolve_if #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic             in_jal;
  logic             in_jalr;
  logic [2:0]       in_funct3;
  logic [XLEN-1:0]  in_pc;
  logic [XLEN-1:0]  in_imm;
  logic [XLEN-1:0]  in_rs1;
  logic [XLEN-1:0]  in_rs2;
  logic             in_pred_taken;
  logic [XLEN-1:0]  in_pred_pc;
  logic [XLEN-1:0]  cmp_op1;
  logic [XLEN-1:0]  cmp_op2;
  logic             cmp_u;
  logic             cmp_eq;
  logic             cmp_less;
  logic             redirect_valid;
  logic             redirect_ready;
  logic [XLEN-1:0]  redirect_pc;
  logic             link_valid;
  logic [XLEN-1:0]  link_data;
  logic             exc_valid;
  logic [CNT_W-1:0] br_cnt;
  logic [CNT_W-1:0] mis_cnt;

  modport slave (
    input  in_valid, in_jal, in_jalr, in_funct3, in_pc, in_imm, in_rs1, in_rs2,
           in_pred_taken, in_pred_pc, cmp_eq, cmp_less, redirect_ready,
    output in_ready, cmp_op1, cmp_op2, cmp_u, redirect_valid, redirect_pc,
           link_valid, link_data, exc_valid, br_cnt, mis_cnt
  );

  modport master (
    output in_valid, in_jal, in_jalr, in_funct3, in_pc, in_imm, in_rs1, in_rs2,
           in_pred_taken, in_pred_pc, cmp_eq, cmp_less, redirect_ready,
    input  in_ready, cmp_op1, cmp_op2, cmp_u, redirect_valid, redirect_pc,
           link_valid, link_data, exc_valid, br_cnt, mis_cnt
  );
endinterface

// File: rtl/branch_resolve.sv
// Execute-stage branch/jump resolution: registers the op, resolves it from the
// external comparator flags, and raises redirect, link and exception results.
module branch_resolve #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
) (
  input logic             clk,
  input logic             rst_n,
  branch_resolve_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EVAL, REDIRECT} state_t;

  state_t state, state_nxt;

  logic            jal_q, jalr_q, pred_taken_q;
  logic [2:0]      funct3_q;
  logic [XLEN-1:0] pc_q, imm_q, rs1_q, rs2_q, pred_pc_q;

  logic            accept, is_jump, taken, illegal, misalign, mispredict, exc;
  logic [XLEN-1:0] seq_pc, jump_sum, target, next_pc;

  assign accept      = bus.in_valid && (state == IDLE);
  assign bus.in_ready = (state == IDLE);
  assign bus.cmp_op1 = rs1_q;
  assign bus.cmp_op2 = rs2_q;
  assign is_jump     = jal_q || jalr_q;
  assign bus.cmp_u   = !is_jump && funct3_q[1];

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    if (is_jump) begin
      taken = 1'b1;
    end else begin
      case (funct3_q)
        3'b000:         taken = bus.cmp_eq;
        3'b001:         taken = !bus.cmp_eq;
        3'b100, 3'b110: taken = bus.cmp_less;
        3'b101, 3'b111: taken = !bus.cmp_less;
        default:        illegal = 1'b1;
      endcase
    end
  end

  // JALR clears bit 0 of its sum; a set bit 1 on a taken target is misaligned.
  assign seq_pc     = pc_q + XLEN'(4);
  assign jump_sum   = rs1_q + imm_q;
  assign target     = jalr_q ? {jump_sum[XLEN-1:1], 1'b0} : (pc_q + imm_q);
  assign next_pc    = taken ? target : seq_pc;
  assign misalign   = taken && target[1];
  assign exc        = illegal || misalign;
  assign mispredict = !illegal &&
                      ((taken != pred_taken_q) || (taken && (target != pred_pc_q)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (accept) state_nxt = EVAL;
      EVAL:     state_nxt = (mispredict && !exc) ? REDIRECT : IDLE;
      REDIRECT: if (bus.redirect_ready) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      jal_q        <= 1'b0;
      jalr_q       <= 1'b0;
      funct3_q     <= '0;
      pc_q         <= '0;
      imm_q        <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      pred_taken_q <= 1'b0;
      pred_pc_q    <= '0;
    end else if (accept) begin
      jal_q        <= bus.in_jal;
      jalr_q       <= bus.in_jalr;
      funct3_q     <= bus.in_funct3;
      pc_q         <= bus.in_pc;
      imm_q        <= bus.in_imm;
      rs1_q        <= bus.in_rs1;
      rs2_q        <= bus.in_rs2;
      pred_taken_q <= bus.in_pred_taken;
      pred_pc_q    <= bus.in_pred_pc;
    end
  end

  // Results and statistics update once, on the single EVAL cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.redirect_valid <= 1'b0;
      bus.redirect_pc    <= '0;
      bus.link_valid     <= 1'b0;
      bus.link_data      <= '0;
      bus.exc_valid      <= 1'b0;
      bus.br_cnt         <= '0;
      bus.mis_cnt        <= '0;
    end else begin
      bus.link_valid <= 1'b0;
      bus.exc_valid  <= 1'b0;
      if (state == EVAL) begin
        bus.exc_valid <= exc;
        if (is_jump) begin
          bus.link_valid <= 1'b1;
          bus.link_data  <= seq_pc;
        end
        if (mispredict && !exc) begin
          bus.redirect_valid <= 1'b1;
          bus.redirect_pc    <= next_pc;
        end
        if (bus.br_cnt != '1) bus.br_cnt <= bus.br_cnt + CNT_W'(1);
        if (mispredict && (bus.mis_cnt != '1)) bus.mis_cnt <= bus.mis_cnt + CNT_W'(1);
      end
      if ((state == REDIRECT) && bus.redirect_ready) bus.redirect_valid <= 1'b0;
    end
  end
endmodule

// File: doc/branch_resolve.md
# branch_resolve

Execute-stage branch resolution unit for the 64-bit RV64I core, sitting directly downstream of the integer comparator. It accepts one branch or jump per handshake, registers the operands, and feeds them to the comparator. From the comparator's eq/less flags it decides the actual outcome, computes the target, and checks it against the fetch prediction. On a mispredict it holds a redirect request until fetch accepts it, and it also produces the link value for JAL/JALR and keeps saturating branch statistics.

## Interface
- XLEN, 64, datapath width (must match comparator)
- CNT_W, 32, width of statistics counters
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  op offered by decode
- in_ready  out  1  unit can accept an op
- in_jal, in_jalr  in  1 each  jump kind (both 0 means conditional branch; both 1 is illegal)
- in_funct3  in  3  branch condition
- in_pc, in_imm, in_rs1, in_rs2  in  XLEN each  pc, sign-extended imm, operands
- in_pred_taken  in  1  fetch prediction
- in_pred_pc  in  XLEN  predicted next pc
- cmp_op1, cmp_op2  out  XLEN  to comparator
- cmp_u  out  1  to comparator, 1 means unsigned
- cmp_eq, cmp_less  in  1  from comparator (combinational)
- redirect_valid  out  1  mispredict redirect request
- redirect_ready  in  1  fetch accepts the redirect
- redirect_pc  out  XLEN  correct next pc
- link_valid  out  1  one-cycle pulse, link_data is valid
- link_data  out  XLEN  pc+4
- exc_valid  out  1  one-cycle pulse on illegal funct3 or misaligned taken target
- br_cnt, mis_cnt  out  CNT_W each  resolved ops, mispredicts

## Operation
- State machine with three states: IDLE, EVAL, REDIRECT. in_ready = (state==IDLE).
- IDLE: when in_valid && in_ready, capture all in_* fields into operand registers and go to EVAL.
- cmp_op1/cmp_op2 are driven from the rs1/rs2 registers at all times.
- cmp_u = funct3[1] for conditional branches; 0 for jumps.
- EVAL computes the outcome:
  - taken: 000 eq; 001 !eq; 100/110 less; 101/111 !less; JAL/JALR always 1.
  - funct3 010/011 on a conditional branch: exc_valid pulse, no redirect, no link; counts in br_cnt only.
- Target rules:
  - Branch/JAL: pc+imm.
  - JALR: (rs1+imm) with bit0 cleared.
  - Not taken: pc+4.
  - All sums are mod 2^XLEN.
- Misalign: a taken target with bit1 set raises an exc_valid pulse and suppresses redirect.
- Mispredict = (taken != pred_taken) || (taken && target != pred_pc).
- EVAL exit:
  - On mispredict (and no exc): load redirect_pc, set redirect_valid, go to REDIRECT; else go to IDLE.
  - Jumps pulse link_valid with link_data = pc+4 on EVAL exit, even on exception.
- REDIRECT: hold redirect_valid and redirect_pc stable. On redirect_ready, clear redirect_valid and go to IDLE on the same edge.
- Counters, updated at EVAL exit:
  - br_cnt increments on every op.
  - mis_cnt increments on every mispredict, including suppressed ones.
  - Both saturate at all-ones.
- Reset (async, any state): state IDLE; redirect_valid, redirect_pc, link_valid, link_data, exc_valid, br_cnt, mis_cnt, and operand registers all 0. in_ready reads 1 during and after reset.

## Timing
- Cycle 0: accept.
- Cycle 1: EVAL. The comparator settles within this cycle; decision is registered at its end.
- Cycle 2: redirect_valid, link_valid, exc_valid, and counters are visible.
- Throughput:
  - Non-mispredicted op: one per 2 cycles (in_ready high again in cycle 2).
  - Mispredicted op: in_ready stays low until the cycle after redirect_ready is sampled high.
- redirect_ready high in cycle 2: redirect_valid is asserted for exactly one cycle.
- redirect_ready already high before REDIRECT is entered has no effect.
- in_valid is ignored outside IDLE; decode must hold its op.
- link_valid and exc_valid are single-cycle pulses.

## Test plan
- Signed compare: BLT with rs1=0xFFFF_FFFF_FFFF_FFFF, rs2=1, pc=0x1000, imm=0x20, pred_taken=0 -> cycle 2 redirect_valid=1, redirect_pc=0x1020, mis_cnt=1. The same operands as BLTU -> not taken, no redirect, br_cnt=2.
- Correct prediction: BEQ with equal operands, pred_taken=1, pred_pc=pc+imm -> no redirect; in_ready back to 1 in cycle 2.
- Redirect backpressure: redirect_ready held 0 for 5 cycles -> redirect_valid and redirect_pc stable for all 5 cycles, in_ready=0 throughout; then in_ready=1 the cycle after the handshake.
- JALR with rs1=0x2001, imm=4, pc=0x3000, pred_pc=0x2004 -> target 0x2004, no redirect, link_valid pulse with link_data=0x3004.
- Exceptions:
  - funct3=010 -> exc_valid pulse, no redirect.
  - Taken branch to 0x1002 -> exc_valid pulse, no redirect, mis_cnt increments.
- Reset: rst_n low while in REDIRECT -> redirect_valid=0 and counters=0 immediately without a clock edge; in_ready=1. br_cnt preloaded near all-ones saturates and does not wrap.
